traffic_seq: RTL and testbench

TRAFFIC_SEQ -- requirements
Module: traffic_seq

---
 rtl/traffic_seq.sv | 160 ++++++++++++++++
 tb/tb_traffic_seq.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_seq.sv
// Traffic-light phase sequencer: per-phase durations, pause/skip controls and a lamp pattern table.
// Optional feature macro TRAFFIC_SEQ_BLINK_EN adds per-phase blink masks and the blink flag.
module traffic_seq #(
    parameter int unsigned NPHASE    = 10,
    parameter int unsigned LIGHTW    = 10,
    parameter int unsigned CW        = 6,
    parameter int unsigned TICK_DIV  = 1024,
    parameter int unsigned BLINK_DIV = 128,
    parameter int unsigned DEF_DUR   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pause,
    input  logic              next_req,
    input  logic              plus_req,
    input  logic              minus_req,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_addr,
    input  logic [LIGHTW-1:0] cfg_pat,
    input  logic [LIGHTW-1:0] cfg_blink,
    output logic [LIGHTW-1:0] lights,
    output logic [3:0]        phase,
    output logic [CW-1:0]     remain,
    output logic [CW-1:0]     dur,
    output logic              paused
);

    localparam int unsigned   PHW       = $clog2(NPHASE);
    localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] DurMax    = '1;
    localparam logic [CW-1:0] DurDef    = CW'(DEF_DUR);
    localparam logic [CW-1:0] DurOne    = CW'(1);
    localparam logic [PW-1:0] PrescLast = PW'(TICK_DIV - 1);
    localparam logic [3:0]    PhaseLast = 4'(NPHASE - 1);

    logic [3:0]        phase_q, phase_d;
    logic [CW-1:0]     remain_q, remain_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [CW-1:0]     dur_q [NPHASE];
    logic [CW-1:0]     dur_d [NPHASE];
    logic [LIGHTW-1:0] pat_q [NPHASE];
    logic [LIGHTW-1:0] lights_q, lights_d;
    logic              paused_q;

    logic              tick;
    logic              advance;
    logic [PHW-1:0]    cur;
    logic [PHW-1:0]    nxt;
    logic [CW-1:0]     cur_dur;
    logic [CW-1:0]     new_dur;
    logic              cfg_wr;
    logic [PHW-1:0]    cfg_idx;

    assign cur     = phase_q[PHW-1:0];
    assign cur_dur = dur_q[cur];
    assign cfg_wr  = cfg_we && ({28'd0, cfg_addr} < NPHASE);
    assign cfg_idx = cfg_addr[PHW-1:0];

    always_comb begin
        tick    = (presc_q == PrescLast);
        presc_d = (tick || next_req) ? '0 : presc_q + 1'b1;
        nxt     = (phase_q == PhaseLast) ? '0 : cur + 1'b1;

        // Simultaneous plus and minus cancel out.
        new_dur = cur_dur;
        if (plus_req && !minus_req && cur_dur != DurMax) begin
            new_dur = cur_dur + 1'b1;
        end else if (minus_req && !plus_req && cur_dur > DurOne) begin
            new_dur = cur_dur - 1'b1;
        end
        dur_d      = dur_q;
        dur_d[cur] = new_dur;

        advance  = next_req || (tick && !pause && remain_q <= DurOne);
        phase_d  = phase_q;
        remain_d = remain_q;
        if (advance) begin
            phase_d  = 4'(nxt);
            remain_d = dur_q[nxt];
        end else begin
            if (tick && !pause) begin
                remain_d = remain_q - 1'b1;
            end
            if (remain_d > new_dur) begin
                remain_d = new_dur;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= '0;
            remain_q <= DurDef;
            presc_q  <= '0;
            lights_q <= '0;
            paused_q <= 1'b0;
            for (int i = 0; i < int'(NPHASE); i++) begin
                dur_q[i] <= DurDef;
                pat_q[i] <= '0;
            end
        end else begin
            phase_q  <= phase_d;
            remain_q <= remain_d;
            presc_q  <= presc_d;
            lights_q <= lights_d;
            paused_q <= pause;
            dur_q    <= dur_d;
            if (cfg_wr) begin
                pat_q[cfg_idx] <= cfg_pat;
            end
        end
    end

`ifdef TRAFFIC_SEQ_BLINK_EN
    localparam int unsigned   BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BlinkLast = BW'(BLINK_DIV - 1);

    logic [LIGHTW-1:0] blink_q [NPHASE];
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic              flag_q, flag_d;

    always_comb begin
        bcnt_d = bcnt_q + 1'b1;
        flag_d = flag_q;
        if (bcnt_q == BlinkLast) begin
            bcnt_d = '0;
            flag_d = ~flag_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_q <= '0;
            flag_q <= 1'b0;
            for (int i = 0; i < int'(NPHASE); i++) begin
                blink_q[i] <= '0;
            end
        end else begin
            bcnt_q <= bcnt_d;
            flag_q <= flag_d;
            if (cfg_wr) begin
                blink_q[cfg_idx] <= cfg_blink;
            end
        end
    end

    assign lights_d = pat_q[cur] & ~(blink_q[cur] & {LIGHTW{flag_q}});
`else
    logic unused_blink;
    assign unused_blink = ^cfg_blink;
    assign lights_d     = pat_q[cur];
`endif

    assign lights = lights_q;
    assign phase  = phase_q;
    assign remain = remain_q;
    assign dur    = cur_dur;
    assign paused = paused_q;

endmodule

// File: tb/tb_traffic_seq.sv
// Scoreboard bench for traffic_seq: stimulus queues expected outputs per cycle, a negedge monitor
// pops and compares them.
module tb_traffic_seq;

    localparam int LIGHTW = 10;
    localparam int CW     = 6;
`ifdef TRAFFIC_SEQ_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    localparam int K_PHASE  = 0;
    localparam int K_REMAIN = 1;
    localparam int K_DUR    = 2;
    localparam int K_LIGHTS = 3;
    localparam int K_PAUSED = 4;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              pause     = 1'b0;
    logic              next_req  = 1'b0;
    logic              plus_req  = 1'b0;
    logic              minus_req = 1'b0;
    logic              cfg_we    = 1'b0;
    logic [3:0]        cfg_addr  = '0;
    logic [LIGHTW-1:0] cfg_pat   = '0;
    logic [LIGHTW-1:0] cfg_blink = '0;
    logic [LIGHTW-1:0] lights;
    logic [3:0]        phase;
    logic [CW-1:0]     remain;
    logic [CW-1:0]     dur;
    logic              paused;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int    at;
        int    kind;
        int    val;
        string name;
    } exp_t;
    exp_t exp_q[$];

    traffic_seq #(
        .NPHASE   (4),
        .LIGHTW   (LIGHTW),
        .CW       (CW),
        .TICK_DIV (8),
        .BLINK_DIV(4),
        .DEF_DUR  (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pause    (pause),
        .next_req (next_req),
        .plus_req (plus_req),
        .minus_req(minus_req),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_pat  (cfg_pat),
        .cfg_blink(cfg_blink),
        .lights   (lights),
        .phase    (phase),
        .remain   (remain),
        .dur      (dur),
        .paused   (paused)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    function automatic int sample(int kind);
        case (kind)
            K_PHASE:  return int'(phase);
            K_REMAIN: return int'(remain);
            K_DUR:    return int'(dur);
            K_LIGHTS: return int'(lights);
            default:  return int'(paused);
        endcase
    endfunction

    function automatic void expect_at(int at, int kind, int val, string name);
        exp_t e;
        e.at   = at;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endfunction

    // Monitor: compare every queued expectation due on this cycle.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].at == cyc) begin
                check(exp_q[i].name, sample(exp_q[i].kind), exp_q[i].val);
                exp_q.delete(i);
            end
        end
    end

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic clear_inputs();
        pause     = 1'b0;
        next_req  = 1'b0;
        plus_req  = 1'b0;
        minus_req = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_pat   = '0;
        cfg_blink = '0;
    endtask

    task automatic do_reset(output int r);
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        r   = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;

        // Reset held from time zero.
        @(negedge clk);
        check("rst_phase", int'(phase), 0);
        check("rst_remain", int'(remain), 3);
        check("rst_dur", int'(dur), 3);
        check("rst_lights", int'(lights), 0);
        check("rst_paused", int'(paused), 0);

        // Free run: 24 cycles per phase, remain 3,2,1.
        do_reset(r);
        expect_at(r + 1, K_DUR, 3, "t1_dur");
        expect_at(r + 1, K_LIGHTS, 0, "t1_lights");
        expect_at(r + 1, K_PAUSED, 0, "t1_paused");
        for (int p = 0; p < 4; p++) begin
            expect_at(r + 24 * p + 1, K_PHASE, p, $sformatf("t1_phase%0d_entry", p));
            expect_at(r + 24 * p + 1, K_REMAIN, 3, $sformatf("t1_remain3_ph%0d", p));
            expect_at(r + 24 * p + 7, K_REMAIN, 3, $sformatf("t1_remain3_late_ph%0d", p));
            expect_at(r + 24 * p + 8, K_REMAIN, 2, $sformatf("t1_remain2_ph%0d", p));
            expect_at(r + 24 * p + 16, K_REMAIN, 1, $sformatf("t1_remain1_ph%0d", p));
            expect_at(r + 24 * p + 23, K_PHASE, p, $sformatf("t1_phase%0d_exit", p));
        end
        expect_at(r + 96, K_PHASE, 0, "t1_wrap_phase");
        expect_at(r + 96, K_REMAIN, 3, "t1_wrap_remain");
        wait_to(r + 97);

        // Pause freezes countdown; next_req advances anyway and clears the prescaler.
        do_reset(r);
        expect_at(r + 11, K_PAUSED, 1, "t2_paused_set");
        expect_at(r + 30, K_REMAIN, 2, "t2_frozen_remain_mid");
        expect_at(r + 50, K_REMAIN, 2, "t2_frozen_remain");
        expect_at(r + 50, K_PHASE, 0, "t2_frozen_phase");
        expect_at(r + 51, K_PHASE, 1, "t2_next_phase");
        expect_at(r + 51, K_REMAIN, 3, "t2_next_remain");
        expect_at(r + 52, K_PAUSED, 0, "t2_paused_clr");
        expect_at(r + 58, K_REMAIN, 3, "t2_presc_cleared");
        expect_at(r + 59, K_REMAIN, 2, "t2_first_tick");
        wait_to(r + 10);
        pause = 1'b1;
        wait_to(r + 50);
        next_req = 1'b1;
        wait_to(r + 51);
        next_req = 1'b0;
        pause    = 1'b0;
        wait_to(r + 60);

        // Duration adjust: saturation at 63 and 1, remain clamp, plus+minus cancel.
        do_reset(r);
        expect_at(r + 62, K_DUR, 62, "t3_dur62");
        expect_at(r + 73, K_DUR, 63, "t3_dur_sat_hi");
        expect_at(r + 73, K_REMAIN, 3, "t3_remain_after_plus");
        expect_at(r + 73, K_PHASE, 1, "t3_phase1");
        expect_at(r + 133, K_DUR, 3, "t3_dur3");
        expect_at(r + 133, K_REMAIN, 3, "t3_remain3");
        expect_at(r + 134, K_REMAIN, 2, "t3_remain_clamp2");
        expect_at(r + 143, K_DUR, 1, "t3_dur_sat_lo");
        expect_at(r + 143, K_REMAIN, 1, "t3_remain_clamp1");
        expect_at(r + 144, K_DUR, 1, "t3_both_dur");
        expect_at(r + 144, K_REMAIN, 1, "t3_both_remain");
        expect_at(r + 146, K_DUR, 3, "t3_ph2_dur");
        expect_at(r + 147, K_PHASE, 3, "t3_adv_phase");
        expect_at(r + 147, K_DUR, 3, "t3_adv_newdur");
        expect_at(r + 147, K_REMAIN, 3, "t3_adv_remain");
        expect_at(r + 149, K_DUR, 1, "t3_ph1_dur_kept");
        expect_at(r + 150, K_PHASE, 2, "t3_back_ph2");
        expect_at(r + 150, K_DUR, 4, "t3_outgoing_dur");
        expect_at(r + 150, K_REMAIN, 4, "t3_outgoing_remain");
        wait_to(r + 2);
        next_req = 1'b1;
        pause    = 1'b1;
        wait_to(r + 3);
        next_req = 1'b0;
        plus_req = 1'b1;
        wait_to(r + 73);
        plus_req  = 1'b0;
        minus_req = 1'b1;
        wait_to(r + 143);
        plus_req = 1'b1;
        wait_to(r + 144);
        plus_req  = 1'b0;
        minus_req = 1'b0;
        wait_to(r + 145);
        next_req = 1'b1;
        wait_to(r + 146);
        plus_req = 1'b1;
        wait_to(r + 147);
        plus_req = 1'b0;
        wait_to(r + 150);
        next_req = 1'b0;
        pause    = 1'b0;
        wait_to(r + 151);

        // Pattern with blink mask on phase 0.
        do_reset(r);
        expect_at(r + 2, K_LIGHTS, 0, "t4_lights_before");
        for (int n = 3; n <= 24; n++) begin
            expect_at(r + n, K_LIGHTS,
                      (BLINK_EN && (((n - 1) / 4) % 2 == 1)) ? 'h3FE : 'h3FF,
                      $sformatf("t4_lights_c%0d", n));
        end
        expect_at(r + 25, K_LIGHTS, 0, "t4_lights_phase1");
        wait_to(r + 1);
        cfg_we    = 1'b1;
        cfg_addr  = 4'd0;
        cfg_pat   = 10'h3FF;
        cfg_blink = 10'h001;
        wait_to(r + 2);
        cfg_we = 1'b0;
        wait_to(r + 26);

        // next_req on the terminal tick of phase 3; out-of-range table write.
        do_reset(r);
        expect_at(r + 95, K_PHASE, 3, "t5_phase3");
        expect_at(r + 95, K_REMAIN, 1, "t5_remain1");
        expect_at(r + 96, K_PHASE, 0, "t5_single_adv");
        expect_at(r + 96, K_REMAIN, 3, "t5_adv_remain");
        expect_at(r + 97, K_PHASE, 0, "t5_no_double");
        expect_at(r + 103, K_REMAIN, 3, "t5_remain_hold");
        expect_at(r + 104, K_REMAIN, 2, "t5_remain_tick");
        expect_at(r + 99, K_LIGHTS, 0, "t5_ph0_untouched");
        expect_at(r + 107, K_PHASE, 1, "t5_phase1");
        expect_at(r + 107, K_LIGHTS, 0, "t5_ph1_untouched");
        expect_at(r + 109, K_LIGHTS, 0, "t5_write_latency");
        expect_at(r + 110, K_LIGHTS, 'h0AA, "t5_write_visible");
        wait_to(r + 95);
        next_req = 1'b1;
        wait_to(r + 96);
        next_req = 1'b0;
        wait_to(r + 97);
        cfg_we   = 1'b1;
        cfg_addr = 4'd5;
        cfg_pat  = 10'h155;
        wait_to(r + 98);
        cfg_we = 1'b0;
        wait_to(r + 105);
        next_req = 1'b1;
        wait_to(r + 106);
        next_req = 1'b0;
        wait_to(r + 108);
        cfg_we   = 1'b1;
        cfg_addr = 4'd1;
        cfg_pat  = 10'h0AA;
        wait_to(r + 109);
        cfg_we = 1'b0;
        wait_to(r + 111);

        // Asynchronous reset mid-countdown in phase 2.
        do_reset(r);
        expect_at(r + 12, K_PHASE, 2, "t6_phase2");
        expect_at(r + 12, K_REMAIN, 2, "t6_remain2");
        expect_at(r + 12, K_LIGHTS, 'h2C3, "t6_lights");
        expect_at(r + 12, K_PAUSED, 1, "t6_paused");
        next_req = 1'b1;
        cfg_we   = 1'b1;
        cfg_addr = 4'd2;
        cfg_pat  = 10'h2C3;
        wait_to(r + 1);
        cfg_we = 1'b0;
        wait_to(r + 2);
        next_req = 1'b0;
        wait_to(r + 10);
        pause = 1'b1;
        wait_to(r + 12);
        #2;
        rst = 1'b1;
        clear_inputs();
        #1;
        check("t6_async_phase", int'(phase), 0);
        check("t6_async_remain", int'(remain), 3);
        check("t6_async_dur", int'(dur), 3);
        check("t6_async_lights", int'(lights), 0);
        check("t6_async_paused", int'(paused), 0);
        @(negedge clk);
        rst = 1'b0;
        r   = cyc;
        expect_at(r + 1, K_PHASE, 0, "t6_post_phase");
        expect_at(r + 7, K_REMAIN, 3, "t6_post_remain3");
        expect_at(r + 8, K_REMAIN, 2, "t6_post_first_tick");
        wait_to(r + 9);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
